// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared constants, IR field helpers and decode bundle for the
// 16-bit five-stage pipeline sequencing/hazard controller.
package pipe_seq_ctrl_pkg;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_HALT  = 5'b00001;
   localparam logic [4:0] OP_LOAD  = 5'b00010;
   localparam logic [4:0] OP_STORE = 5'b00011;
   localparam logic [4:0] OP_SLL   = 5'b00100;
   localparam logic [4:0] OP_SLA   = 5'b00101;
   localparam logic [4:0] OP_SRL   = 5'b00110;
   localparam logic [4:0] OP_SRA   = 5'b00111;
   localparam logic [4:0] OP_ADD   = 5'b01000;
   localparam logic [4:0] OP_ADDI  = 5'b01001;
   localparam logic [4:0] OP_SUB   = 5'b01010;
   localparam logic [4:0] OP_SUBI  = 5'b01011;
   localparam logic [4:0] OP_CMP   = 5'b01100;
   localparam logic [4:0] OP_AND   = 5'b01101;
   localparam logic [4:0] OP_OR    = 5'b01110;
   localparam logic [4:0] OP_XOR   = 5'b01111;
   localparam logic [4:0] OP_LDIH  = 5'b10000;
   localparam logic [4:0] OP_ADDC  = 5'b10001;
   localparam logic [4:0] OP_SUBC  = 5'b10010;
   localparam logic [4:0] OP_JUMP  = 5'b11000;
   localparam logic [4:0] OP_JMPR  = 5'b11001;
   localparam logic [4:0] OP_BZ    = 5'b11010;
   localparam logic [4:0] OP_BNZ   = 5'b11011;
   localparam logic [4:0] OP_BN    = 5'b11100;
   localparam logic [4:0] OP_BNN   = 5'b11101;
   localparam logic [4:0] OP_BC    = 5'b11110;
   localparam logic [4:0] OP_BNC   = 5'b11111;

   localparam logic [15:0] NOP_IR = 16'h0000;

   localparam logic STATE_EXEC = 1'b1;
   localparam logic STATE_IDLE = 1'b0;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam int IR_OP_HI = 15;
   localparam int IR_OP_LO = 11;
   localparam int IR_R1_HI = 10;
   localparam int IR_R1_LO = 8;
   localparam int IR_R2_HI = 6;
   localparam int IR_R2_LO = 4;
   localparam int IR_R3_HI = 2;
   localparam int IR_R3_LO = 0;

   typedef struct packed {
      logic writes_r1;
      logic reads_r1;
      logic reads_r2;
      logic reads_r3;
      logic is_branch;
      logic is_load;
   } dec_t;

   function automatic logic [4:0] ir_op(input logic [15:0] ir);
      return ir[IR_OP_HI:IR_OP_LO];
   endfunction

   function automatic logic [2:0] ir_r1(input logic [15:0] ir);
      return ir[IR_R1_HI:IR_R1_LO];
   endfunction

   function automatic logic [2:0] ir_r2(input logic [15:0] ir);
      return ir[IR_R2_HI:IR_R2_LO];
   endfunction

   function automatic logic [2:0] ir_r3(input logic [15:0] ir);
      return ir[IR_R3_HI:IR_R3_LO];
   endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Pipeline-facing bundle of the sequencing controller: stage IRs
// and flags in, run state, hazard controls and debug counters out.
interface pipe_seq_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [15:0]      id_ir;
   logic [15:0]      ex_ir;
   logic [15:0]      mem_ir;
   logic [15:0]      wb_ir;
   logic             zf;
   logic             nf;
   logic             cf;
   logic             state;
   logic             stall;
   logic             flush;
   logic             pc_sel;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      output start, id_ir, ex_ir, mem_ir, wb_ir,
      output zf, nf, cf,
      input  state, stall, flush, pc_sel,
      input  fwd_a, fwd_b, cycle_cnt, instr_cnt
   );

   modport slave (
      input  start, id_ir, ex_ir, mem_ir, wb_ir,
      input  zf, nf, cf,
      output state, stall, flush, pc_sel,
      output fwd_a, fwd_b, cycle_cnt, instr_cnt
   );
endinterface

// File: rtl/pipe_seq_ctrl_ir_decode.sv
// Opcode classifier: register write/read usage, branch and load flags.
module pipe_seq_ctrl_ir_decode
   import pipe_seq_ctrl_pkg::*;
(
   input  logic [4:0] op_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o = '0;
      unique case (1'b1)
         (op_i == OP_LOAD): begin
            dec_o.writes_r1 = 1'b1;
            dec_o.reads_r2  = 1'b1;
            dec_o.is_load   = 1'b1;
         end
         (op_i == OP_STORE): begin
            dec_o.reads_r1 = 1'b1;
            dec_o.reads_r2 = 1'b1;
         end
         (op_i inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
                       OP_AND, OP_OR, OP_XOR}): begin
            dec_o.writes_r1 = 1'b1;
            dec_o.reads_r2  = 1'b1;
            dec_o.reads_r3  = 1'b1;
         end
         (op_i == OP_CMP): begin
            dec_o.reads_r2 = 1'b1;
            dec_o.reads_r3 = 1'b1;
         end
         // shift amount sits in the r3 field as an immediate
         (op_i inside {OP_SLL, OP_SLA, OP_SRL, OP_SRA}): begin
            dec_o.writes_r1 = 1'b1;
            dec_o.reads_r2  = 1'b1;
         end
         (op_i inside {OP_ADDI, OP_SUBI, OP_LDIH}): begin
            dec_o.writes_r1 = 1'b1;
         end
         (op_i == OP_JUMP): begin
            dec_o.is_branch = 1'b1;
         end
         (op_i inside {OP_JMPR, OP_BZ, OP_BNZ, OP_BN,
                       OP_BNN, OP_BC, OP_BNC}): begin
            dec_o.is_branch = 1'b1;
            dec_o.reads_r1  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Run FSM, load-use stall, branch flush, EX operand forwarding
// and debug counters for the five-stage pipeline.
module pipe_seq_ctrl
   import pipe_seq_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic           clock,
   input  logic           reset,
   pipe_seq_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ins_q, ins_d;

   dec_t id_dec, ex_dec, mem_dec, wb_dec;

   logic [4:0] id_op, ex_op, mem_op, wb_op;
   logic [2:0] id_r1, id_r2, id_r3;
   logic [2:0] ex_r1, ex_r2, ex_r3;
   logic [2:0] mem_r1, wb_r1;

   assign id_op  = ir_op(bus.id_ir);
   assign ex_op  = ir_op(bus.ex_ir);
   assign mem_op = ir_op(bus.mem_ir);
   assign wb_op  = ir_op(bus.wb_ir);
   assign id_r1  = ir_r1(bus.id_ir);
   assign id_r2  = ir_r2(bus.id_ir);
   assign id_r3  = ir_r3(bus.id_ir);
   assign ex_r1  = ir_r1(bus.ex_ir);
   assign ex_r2  = ir_r2(bus.ex_ir);
   assign ex_r3  = ir_r3(bus.ex_ir);
   assign mem_r1 = ir_r1(bus.mem_ir);
   assign wb_r1  = ir_r1(bus.wb_ir);

   pipe_seq_ctrl_ir_decode u_dec_id (
      .op_i  (id_op),
      .dec_o (id_dec)
   );

   pipe_seq_ctrl_ir_decode u_dec_ex (
      .op_i  (ex_op),
      .dec_o (ex_dec)
   );

   pipe_seq_ctrl_ir_decode u_dec_mem (
      .op_i  (mem_op),
      .dec_o (mem_dec)
   );

   pipe_seq_ctrl_ir_decode u_dec_wb (
      .op_i  (wb_op),
      .dec_o (wb_dec)
   );

   logic exec;
   assign exec = (state_q == S_EXEC);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (bus.start) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (wb_op == OP_HALT) state_d = S_HALT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cyc_d = cyc_q;
      ins_d = ins_q;
      if (exec) begin
         cyc_d = cyc_q + CNT_W'(1);
         if (wb_op != OP_NOP) ins_d = ins_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         ins_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         ins_q   <= ins_d;
      end
   end

   logic taken;
   always_comb begin
      taken = 1'b0;
      unique case (mem_op)
         OP_JUMP, OP_JMPR: taken = 1'b1;
         OP_BZ:            taken = bus.zf;
         OP_BNZ:           taken = ~bus.zf;
         OP_BN:            taken = bus.nf;
         OP_BNN:           taken = ~bus.nf;
         OP_BC:            taken = bus.cf;
         OP_BNC:           taken = ~bus.cf;
         default:          taken = 1'b0;
      endcase
   end

   logic ld_use;
   assign ld_use = ex_dec.is_load &
                   ((id_dec.reads_r1 & (id_r1 == ex_r1)) |
                    (id_dec.reads_r2 & (id_r2 == ex_r1)) |
                    (id_dec.reads_r3 & (id_r3 == ex_r1)));

   // a LOAD in MEM has no data yet, so only ALU results forward from MEM
   logic       mem_fw_ok;
   logic [2:0] src_b;
   logic [1:0] fwd_a_raw, fwd_b_raw;

   assign mem_fw_ok = mem_dec.writes_r1 & ~mem_dec.is_load &
                      ~mem_dec.is_branch;
   assign src_b     = (ex_op == OP_STORE) ? ex_r1 : ex_r3;

   assign fwd_a_raw =
      (mem_fw_ok && mem_r1 == ex_r2)        ? FWD_MEM :
      (wb_dec.writes_r1 && wb_r1 == ex_r2) ? FWD_WB  :
                                             FWD_REG;
   assign fwd_b_raw =
      (mem_fw_ok && mem_r1 == src_b)        ? FWD_MEM :
      (wb_dec.writes_r1 && wb_r1 == src_b) ? FWD_WB  :
                                             FWD_REG;

   assign bus.state     = exec ? STATE_EXEC : STATE_IDLE;
   assign bus.flush     = exec & taken;
   assign bus.pc_sel    = exec & taken;
   assign bus.stall     = exec & ld_use & ~taken;
   assign bus.fwd_a     = exec ? fwd_a_raw : FWD_REG;
   assign bus.fwd_b     = exec ? fwd_b_raw : FWD_REG;
   assign bus.cycle_cnt = cyc_q;
   assign bus.instr_cnt = ins_q;

   logic unused_ok;
   assign unused_ok = ^{bus.id_ir, bus.ex_ir, bus.mem_ir, bus.wb_ir,
                        id_dec, ex_dec, mem_dec, wb_dec};

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed plus randomized bench for pipe_seq_ctrl against a
// set-based behavioural model of the sequencing rules.
module tb_pipe_seq_ctrl;
   import pipe_seq_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   pipe_seq_ctrl_if #(.CNT_W(16)) bus ();

   pipe_seq_ctrl #(.CNT_W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   bit          m_run;
   logic [15:0] m_cyc;
   logic [15:0] m_ins;

   logic [4:0] op_tab [26] = '{
      OP_NOP, OP_LOAD, OP_STORE, OP_SLL, OP_SLA, OP_SRL, OP_SRA,
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CMP, OP_AND, OP_OR,
      OP_XOR, OP_LDIH, OP_ADDC, OP_SUBC, OP_JUMP, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [4:0] op,
      input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3);
      return {op, r1, 1'b0, r2, 1'b0, r3};
   endfunction

   function automatic bit writes(input logic [4:0] op);
      return op inside {OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC,
                        OP_SUB, OP_SUBI, OP_SUBC, OP_AND, OP_OR,
                        OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
   endfunction

   // set of registers an instruction reads, as an 8-bit membership mask
   function automatic logic [7:0] rd_set(input logic [15:0] ir);
      logic [4:0] op;
      logic [7:0] s;
      op = ir[15:11];
      s  = '0;
      if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND,
                     OP_OR, OP_XOR, OP_CMP})
         s = (8'd1 << ir[6:4]) | (8'd1 << ir[2:0]);
      else if (op inside {OP_LOAD, OP_SLL, OP_SLA, OP_SRL, OP_SRA})
         s = 8'd1 << ir[6:4];
      else if (op == OP_STORE)
         s = (8'd1 << ir[10:8]) | (8'd1 << ir[6:4]);
      else if (op inside {OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN,
                          OP_BC, OP_BNC})
         s = 8'd1 << ir[10:8];
      return s;
   endfunction

   function automatic bit br_taken(input logic [15:0] ir,
      input bit z, input bit n, input bit c);
      case (ir[15:11])
         OP_JUMP, OP_JMPR: return 1'b1;
         OP_BZ:  return z;
         OP_BNZ: return !z;
         OP_BN:  return n;
         OP_BNN: return !n;
         OP_BC:  return c;
         OP_BNC: return !c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] src_sel(input logic [2:0] r,
      input logic [15:0] mem, input logic [15:0] wb);
      if (writes(mem[15:11]) && mem[15:11] != OP_LOAD && mem[10:8] == r)
         return 2'd1;
      if (writes(wb[15:11]) && wb[10:8] == r)
         return 2'd2;
      return 2'd0;
   endfunction

   task automatic drive(input bit st, input logic [15:0] id,
      input logic [15:0] ex, input logic [15:0] mem,
      input logic [15:0] wb, input bit z, input bit n, input bit c);
      bus.start  = st;
      bus.id_ir  = id;
      bus.ex_ir  = ex;
      bus.mem_ir = mem;
      bus.wb_ir  = wb;
      bus.zf     = z;
      bus.nf     = n;
      bus.cf     = c;
      #1;
   endtask

   // compare every output against the model, then advance one clock
   task automatic tick();
      bit          e_fl, e_st;
      logic [1:0]  e_fa, e_fb;
      logic [7:0]  rs;
      logic [2:0]  rb;
      e_fl = 0; e_st = 0; e_fa = 0; e_fb = 0;
      if (m_run) begin
         e_fl = br_taken(bus.mem_ir, bus.zf, bus.nf, bus.cf);
         rs   = rd_set(bus.id_ir);
         e_st = !e_fl && bus.ex_ir[15:11] == OP_LOAD &&
                rs[bus.ex_ir[10:8]];
         rb   = (bus.ex_ir[15:11] == OP_STORE) ? bus.ex_ir[10:8]
                                                : bus.ex_ir[2:0];
         e_fa = src_sel(bus.ex_ir[6:4], bus.mem_ir, bus.wb_ir);
         e_fb = src_sel(rb, bus.mem_ir, bus.wb_ir);
      end
      chk("state", bus.state, m_run);
      chk("cycle_cnt", bus.cycle_cnt, m_cyc);
      chk("instr_cnt", bus.instr_cnt, m_ins);
      chk("flush", bus.flush, e_fl);
      chk("pc_sel", bus.pc_sel, e_fl);
      chk("stall", bus.stall, e_st);
      chk("fwd_a", bus.fwd_a, e_fa);
      chk("fwd_b", bus.fwd_b, e_fb);
      if (reset) begin
         m_run = 0; m_cyc = '0; m_ins = '0;
      end else if (m_run) begin
         m_cyc = m_cyc + 16'd1;
         if (bus.wb_ir[15:11] != OP_NOP) m_ins = m_ins + 16'd1;
         if (bus.wb_ir[15:11] == OP_HALT) m_run = 0;
      end else if (bus.start) begin
         m_run = 1;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [15:0] rnd_ir(input bit allow_halt);
      logic [15:0] ir;
      ir = mk(op_tab[$urandom_range(25)], 3'($urandom_range(3)),
              3'($urandom_range(3)), 3'($urandom_range(3)));
      ir[7] = 1'($urandom);
      ir[3] = 1'($urandom);
      if (allow_halt && $urandom_range(39) == 0) ir[15:11] = OP_HALT;
      return ir;
   endfunction

   logic [15:0] hold_c, hold_i;
   logic [15:0] ld3, add_use3;

   initial begin
      reset = 1'b1;
      drive(0, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      @(posedge clock);
      @(negedge clock);
      m_run = 0; m_cyc = '0; m_ins = '0;
      ld3      = mk(OP_LOAD, 3'd3, 3'd0, 3'd0);
      add_use3 = mk(OP_ADD, 3'd1, 3'd3, 3'd2);

      drive(0, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      chk("rst_state", bus.state, 0);
      chk("rst_cyc", bus.cycle_cnt, 0);
      tick();
      reset = 1'b0;

      drive(1, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      tick();
      drive(0, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      chk("start_state", bus.state, 1);
      repeat (3) tick();
      chk("cyc_after3", bus.cycle_cnt, 3);

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_state", bus.state, 0);
      chk("midrst_cyc", bus.cycle_cnt, 0);
      chk("midrst_ins", bus.instr_cnt, 0);

      drive(1, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      tick();

      drive(0, add_use3, ld3, NOP_IR, NOP_IR, 0, 0, 0);
      chk("lduse_stall", bus.stall, 1);
      tick();
      drive(0, add_use3, NOP_IR, ld3, NOP_IR, 0, 0, 0);
      chk("lduse_clear", bus.stall, 0);
      tick();

      drive(0, NOP_IR, mk(OP_ADD, 3'd4, 3'd2, 3'd2),
            mk(OP_ADD, 3'd2, 3'd0, 3'd1),
            mk(OP_SUB, 3'd2, 3'd0, 3'd1), 0, 0, 0);
      chk("fwd_mem_a", bus.fwd_a, 1);
      chk("fwd_mem_b", bus.fwd_b, 1);
      tick();
      bus.mem_ir = NOP_IR; #1;
      chk("fwd_wb_a", bus.fwd_a, 2);
      chk("fwd_wb_b", bus.fwd_b, 2);
      tick();
      bus.mem_ir = mk(OP_CMP, 3'd2, 3'd2, 3'd2); #1;
      chk("fwd_cmp_a", bus.fwd_a, 2);
      tick();
      drive(0, NOP_IR, mk(OP_ADD, 3'd5, 3'd0, 3'd1),
            mk(OP_ADDI, 3'd0, 3'd0, 3'd0), NOP_IR, 0, 0, 0);
      chk("fwd_r0_a", bus.fwd_a, 1);
      tick();
      drive(0, NOP_IR, mk(OP_STORE, 3'd6, 3'd1, 3'd2),
            mk(OP_XOR, 3'd6, 3'd0, 3'd0), NOP_IR, 0, 0, 0);
      chk("fwd_st_b", bus.fwd_b, 1);
      tick();

      drive(0, NOP_IR, NOP_IR, mk(OP_BZ, 3'd1, 3'd0, 3'd0),
            NOP_IR, 1, 0, 0);
      chk("bz_pcsel", bus.pc_sel, 1);
      chk("bz_flush", bus.flush, 1);
      tick();
      bus.zf = 0; #1;
      chk("bz_nt_pcsel", bus.pc_sel, 0);
      chk("bz_nt_flush", bus.flush, 0);
      tick();
      drive(0, NOP_IR, NOP_IR, mk(OP_JUMP, 3'd0, 3'd0, 3'd0),
            NOP_IR, 0, 1, 1);
      chk("jump_taken", bus.pc_sel, 1);
      tick();
      drive(0, add_use3, ld3, mk(OP_BNC, 3'd1, 3'd0, 3'd0),
            NOP_IR, 0, 0, 0);
      chk("fos_flush", bus.flush, 1);
      chk("fos_stall", bus.stall, 0);
      tick();

      drive(0, NOP_IR, NOP_IR, NOP_IR, mk(OP_HALT, 3'd0, 3'd0, 3'd0),
            0, 0, 0);
      tick();
      hold_c = m_cyc;
      hold_i = m_ins;
      drive(0, add_use3, ld3, mk(OP_JUMP, 3'd0, 3'd0, 3'd0),
            mk(OP_ADD, 3'd1, 3'd0, 3'd0), 0, 0, 0);
      chk("halt_state", bus.state, 0);
      chk("halt_flush", bus.flush, 0);
      repeat (3) tick();
      chk("halt_cyc_hold", bus.cycle_cnt, hold_c);
      chk("halt_ins_hold", bus.instr_cnt, hold_i);
      bus.start = 1'b1; #1;
      tick();
      drive(0, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      chk("resume_state", bus.state, 1);
      tick();

      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, NOP_IR, NOP_IR, NOP_IR,
               mk(op_tab[1 + (i % 20)], 3'd1, 3'd2, 3'd3), 0, 0, 0);
         tick();
      end
      drive(0, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      chk("instr5", bus.instr_cnt, 5);
      tick();

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(199) == 0);
         drive(($urandom_range(9) == 0), rnd_ir(0), rnd_ir(0),
               rnd_ir(0), rnd_ir(1), 1'($urandom), 1'($urandom),
               1'($urandom));
         tick();
      end

      reset = 1'b1;
      drive(0, NOP_IR, NOP_IR, NOP_IR, NOP_IR, 0, 0, 0);
      tick();
      reset = 1'b0;
      bus.start = 1'b1; #1;
      tick();
      bus.start = 1'b0; #1;
      for (int i = 0; i < 65535; i++) tick();
      chk("cyc_ffff", bus.cycle_cnt, 16'hFFFF);
      tick();
      chk("cyc_wrap", bus.cycle_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Sequencing and hazard controller for the 16-bit five-stage pipeline (IF/ID/EX/MEM/WB).
- Owns the run state machine that drives the `state` input of every stage, including EX.
- Detects load-use hazards (stall), resolves conditional branches from the EX flag registers (flush), and selects EX operand forwarding.
- Keeps cycle and retired-instruction counters for debug.

Parameters:
- CNT_W, 16, width of the cycle and retired-instruction counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; IDLE or HALT -> EXEC
- id_ir  in  16  instruction in ID
- ex_ir  in  16  instruction in EX
- mem_ir  in  16  instruction in MEM
- wb_ir  in  16  instruction in WB
- zf, nf, cf  in  1 each  flag registers written by the EX stage
- state  out  1  1 = exec, 0 = idle; drives every stage
- stall  out  1  hold PC and IF/ID; inject NOP into EX
- flush  out  1  replace IF/ID and ID/EX contents with NOP
- pc_sel  out  1  1 = load PC from branch target
- fwd_a, fwd_b  out  2 each  operand source: 0 regfile, 1 MEM result, 2 WB result
- cycle_cnt  out  CNT_W  cycles spent in EXEC
- instr_cnt  out  CNT_W  non-NOP instructions reaching WB

Behaviour:
- IR fields: op = ir[15:11], r1 = ir[10:8] (destination; also the data source for STORE), r2 = ir[6:4], r3 = ir[2:0]. NOP op = 5'b00000.
- FSM states are registered:
  - IDLE -> EXEC on start.
  - EXEC -> HALT when wb_ir op == HALT.
  - HALT -> EXEC on start.
  - state = 1 only in EXEC.
- Reset is synchronous: FSM = IDLE; counters = 0. All outputs are 0 in the cycle after reset is sampled, including mid-operation.
- Outside EXEC: stall, flush, pc_sel, fwd_a and fwd_b are 0, and the counters hold.
- Load-use detection (combinational):
  - Condition: ex_ir op == LOAD, and id_ir reads ex_ir.r1. A read is r2/r3 per the opcode's source-use class, and r1 for STORE and branch-register ops.
  - Response: stall = 1 for exactly one cycle. On the next cycle the LOAD has moved to MEM, so the condition clears.
- Branch resolution (combinational on mem_ir and flags):
  - JUMP and JMPR are always taken.
  - BZ/BNZ test zf==1 / zf==0; BN/BNN test nf; BC/BNC test cf.
  - Taken: pc_sel = 1 and flush = 1 in the same cycle.
- Simultaneous events: flush dominates. When flush = 1, stall is forced to 0.
- Forwarding (combinational on ex_ir sources; source A = r2, source B = r3, or r1 for STORE data):
  - Select 1 when mem_ir writes the matching register and is not LOAD/STORE/branch/NOP.
  - Select 2 when wb_ir writes the matching register (LOAD included).
  - If both match, MEM (1) wins.
  - Register 0 is not special.
- Write-class opcodes: LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA.
  - CMP, STORE, branches, HALT and NOP do not write.
- Counters:
  - cycle_cnt increments every EXEC cycle.
  - instr_cnt increments when state is EXEC and wb_ir op != NOP.
  - Both wrap modulo 2^CNT_W without saturating.
- All decode logic is combinational; only the FSM and the counters are registered.

Decomposition:
- Opcodes, the exec/idle encodings and the NOP constant come from the shared define header.
- New shared constants go in the same header: the FWD_REG/FWD_MEM/FWD_WB encodings, and the IR field bit positions.
- One sub-module, ir_decode: op -> {writes_r1, reads_r1, reads_r2, reads_r3, is_branch, is_load}.
  - Instantiated four times (id, ex, mem, wb).

Test Plan:
- Reset and start:
  - Assert reset for 2 cycles while in EXEC -> next cycle state=0 and cnts=0.
  - Pulse start -> state=1 one cycle later; cycle_cnt=3 after 3 EXEC cycles.
- Load-use:
  - ex_ir = LOAD r3, id_ir = ADD r1,r3,r2 -> stall=1 for one cycle.
  - Then ex_ir = NOP -> stall=0.
- Forwarding:
  - mem_ir = ADD r2,..; wb_ir = SUB r2,..; ex_ir = ADD r4,r2,r2 -> fwd_a=1, fwd_b=1.
  - Remove mem_ir -> fwd_a=2, fwd_b=2.
  - mem_ir = CMP -> no forwarding from MEM.
- Branches:
  - mem_ir = BZ with zf=1 -> pc_sel=1, flush=1.
  - zf=0 -> both 0.
  - mem_ir = JUMP -> taken regardless of flags.
- Flush over stall: taken BNC (cf=0) in MEM plus LOAD-use pair in EX/ID -> flush=1, stall=0.
- Halt and counting:
  - wb_ir = HALT -> state=0 next cycle; counters frozen.
  - Start resumes.
  - 5 non-NOP WB instructions -> instr_cnt=5.
  - Preload cycle_cnt to 16'hFFFF -> wraps to 0.
